epl_correlator: RTL and testbench

// - Consumes the early/prompt/late chip stream and the dump_enable epoch from code_gen/code_nco.
// - Wipes the code off carrier-mixed I/Q baseband samples and integrates six correlations (IE,QE,IP,QP,IL,QL).
// - On each dump_enable, latches the integrals into a result bank and offers them to the tracking CPU.
// - The CPU reads the bank through a valid/ready handshake.

---
 rtl/epl_correlator.sv | 227 ++++++++++++++++++++++
 tb/tb_epl_correlator.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/epl_correlator.sv
// epl_correlator: early/prompt/late code-wipe correlator.
// The block takes I/Q baseband samples and wipes the E/P/L chips off them.
// It integrates six correlations over one code epoch.
// On each dump_enable pulse it latches the integrals into a result bank.
// The CPU reads that bank through a valid/ready handshake.
// Optional feature macro: ACC_SAT_EN. When defined, accumulators clamp
// instead of wrapping, and a per-period saturation flag is reported on sat.
// Accumulator index order throughout: 0=IE 1=QE 2=IP 3=QP 4=IL 5=QL.
// ACC_W must be larger than IN_W, so negating the most negative sample
// cannot overflow once it has been sign-extended.

module epl_correlator #(
    parameter int IN_W  = 3,
    parameter int ACC_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  i_in,
    input  logic [IN_W-1:0]  q_in,
    input  logic             early,
    input  logic             prompt,
    input  logic             late,
    input  logic             dump_enable,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [ACC_W-1:0] ie,
    output logic [ACC_W-1:0] qe,
    output logic [ACC_W-1:0] ip,
    output logic [ACC_W-1:0] qp,
    output logic [ACC_W-1:0] il,
    output logic [ACC_W-1:0] ql,
    output logic [CNT_W-1:0] n_samples,
    output logic             overrun,
    output logic             sat
);

    localparam int NCORR = 6;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [ACC_W-1:0] ext_i;
    logic [ACC_W-1:0] ext_q;
    logic [ACC_W-1:0] neg_i;
    logic [ACC_W-1:0] neg_q;
    logic [ACC_W-1:0] term     [NCORR];
    logic [ACC_W-1:0] acc_sum  [NCORR];
    logic [CNT_W-1:0] cnt_sum;
    logic             xfer;
    logic             overwrite;

    logic [ACC_W-1:0] acc_q    [NCORR];
    logic [ACC_W-1:0] acc_d    [NCORR];
    logic [ACC_W-1:0] bank_q   [NCORR];
    logic [ACC_W-1:0] bank_d   [NCORR];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] n_samples_q;
    logic [CNT_W-1:0] n_samples_d;
    logic             rd_valid_q;
    logic             rd_valid_d;
    logic             overrun_q;
    logic             overrun_d;

`ifdef ACC_SAT_EN
    logic             clamp_any;
    logic [ACC_W:0]   sat_tmp;
    logic             period_sat_q;
    logic             period_sat_d;
    logic             sat_q;
    logic             sat_d;

    // Signed add that clamps to the ACC_W range; the MSB of the result flags a clamp.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
        logic [ACC_W:0]   wide;
        logic [ACC_W-1:0] res;
        logic             clamped;
        wide = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (wide[ACC_W] != wide[ACC_W-1]) begin
            clamped = 1'b1;
            if (wide[ACC_W]) begin
                res = {1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                res = {1'b0, {(ACC_W-1){1'b1}}};
            end
        end else begin
            clamped = 1'b0;
            res     = wide[ACC_W-1:0];
        end
        return {clamped, res};
    endfunction
`endif

    // Sign-extend the samples and apply the chip mapping (chip 1 negates the sample).
    always_comb begin
        ext_i   = {{(ACC_W-IN_W){i_in[IN_W-1]}}, i_in};
        ext_q   = {{(ACC_W-IN_W){q_in[IN_W-1]}}, q_in};
        neg_i   = {ACC_W{1'b0}} - ext_i;
        neg_q   = {ACC_W{1'b0}} - ext_q;
        term[0] = early  ? neg_i : ext_i;
        term[1] = early  ? neg_q : ext_q;
        term[2] = prompt ? neg_i : ext_i;
        term[3] = prompt ? neg_q : ext_q;
        term[4] = late   ? neg_i : ext_i;
        term[5] = late   ? neg_q : ext_q;
    end

    // Accumulator-plus-this-cycle value, which is used both to continue a period and to dump it.
    always_comb begin
`ifdef ACC_SAT_EN
        clamp_any = 1'b0;
        sat_tmp   = {(ACC_W+1){1'b0}};
`endif
        for (int k = 0; k < NCORR; k++) begin
            if (in_valid) begin
`ifdef ACC_SAT_EN
                sat_tmp    = sat_add(acc_q[k], term[k]);
                acc_sum[k] = sat_tmp[ACC_W-1:0];
                clamp_any  = clamp_any | sat_tmp[ACC_W];
`else
                acc_sum[k] = acc_q[k] + term[k];
`endif
            end else begin
                acc_sum[k] = acc_q[k];
            end
        end
        if (in_valid && (cnt_q != CNT_MAX)) begin
            cnt_sum = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_sum = cnt_q;
        end
    end

    // Next-state logic for the period accumulators, the result bank and the handshake.
    always_comb begin
        xfer        = rd_valid_q & rd_ready;
        overwrite   = dump_enable & rd_valid_q & ~rd_ready;
        bank_d      = bank_q;
        n_samples_d = n_samples_q;
        rd_valid_d  = rd_valid_q;
        overrun_d   = overrun_q;
        acc_d       = acc_sum;
        cnt_d       = cnt_sum;
        if (dump_enable) begin
            bank_d      = acc_sum;
            n_samples_d = cnt_sum;
            rd_valid_d  = 1'b1;
            for (int k = 0; k < NCORR; k++) begin
                acc_d[k] = {ACC_W{1'b0}};
            end
            cnt_d = {CNT_W{1'b0}};
        end else if (xfer) begin
            rd_valid_d = 1'b0;
        end else begin
            rd_valid_d = rd_valid_q;
        end
        // Overwrite and transfer are mutually exclusive, so only one of the two can fire.
        if (overwrite) begin
            overrun_d = 1'b1;
        end else if (xfer) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

`ifdef ACC_SAT_EN
    // The per-period clamp flag is moved into sat at the dump, and the next period starts clean.
    always_comb begin
        if (dump_enable) begin
            period_sat_d = 1'b0;
            sat_d        = period_sat_q | clamp_any;
        end else begin
            period_sat_d = period_sat_q | clamp_any;
            sat_d        = sat_q;
        end
    end

    // Saturation flag registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            period_sat_q <= 1'b0;
            sat_q        <= 1'b0;
        end else begin
            period_sat_q <= period_sat_d;
            sat_q        <= sat_d;
        end
    end

    assign sat = sat_q;
`else
    assign sat = 1'b0;
`endif

    // Registers for the accumulators, the result bank and the handshake state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < NCORR; k++) begin
                acc_q[k]  <= {ACC_W{1'b0}};
                bank_q[k] <= {ACC_W{1'b0}};
            end
            cnt_q       <= {CNT_W{1'b0}};
            n_samples_q <= {CNT_W{1'b0}};
            rd_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            bank_q      <= bank_d;
            cnt_q       <= cnt_d;
            n_samples_q <= n_samples_d;
            rd_valid_q  <= rd_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign ie        = bank_q[0];
    assign qe        = bank_q[1];
    assign ip        = bank_q[2];
    assign qp        = bank_q[3];
    assign il        = bank_q[4];
    assign ql        = bank_q[5];
    assign n_samples = n_samples_q;
    assign rd_valid  = rd_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_epl_correlator.sv
// Bench for epl_correlator.
// It runs directed scenarios and then random traffic.
// A behavioural model integrates each period with integer arithmetic.
// The model tracks the bank, valid and overrun state from the handshake rules.
// A second instance with ACC_W=8 covers the overflow behaviour.

module tb_epl_correlator;

    localparam int IN_W  = 3;
    localparam int ACC_W = 16;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rstn;
    logic             in_valid;
    logic [IN_W-1:0]  i_in;
    logic [IN_W-1:0]  q_in;
    logic             early;
    logic             prompt;
    logic             late;
    logic             dump_enable;
    logic             rd_ready;
    logic             rd_valid;
    logic [ACC_W-1:0] ie, qe, ip, qp, il, ql;
    logic [CNT_W-1:0] n_samples;
    logic             overrun;
    logic             sat;

    logic             rd_valid8;
    logic [7:0]       ie8, qe8, ip8, qp8, il8, ql8;
    logic [CNT_W-1:0] n_samples8;
    logic             overrun8;
    logic             sat8;

    epl_correlator #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .i_in(i_in), .q_in(q_in),
        .early(early), .prompt(prompt), .late(late), .dump_enable(dump_enable),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .ie(ie), .qe(qe), .ip(ip),
        .qp(qp), .il(il), .ql(ql), .n_samples(n_samples), .overrun(overrun), .sat(sat)
    );

    epl_correlator #(.IN_W(IN_W), .ACC_W(8), .CNT_W(CNT_W)) dut8 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .i_in(i_in), .q_in(q_in),
        .early(early), .prompt(prompt), .late(late), .dump_enable(dump_enable),
        .rd_ready(rd_ready), .rd_valid(rd_valid8), .ie(ie8), .qe(qe8), .ip(ip8),
        .qp(qp8), .il(il8), .ql(ql8), .n_samples(n_samples8), .overrun(overrun8), .sat(sat8)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: plain integers, kept inside the ACC_W signed range.
    int m_acc [6];
    int m_bank [6];
    int m_cnt;
    int m_n;
    bit m_satf;
    bit m_sat;
    bit m_valid;
    bit m_over;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] e16(input int v);
        logic [31:0] r;
        r = v;
        return {16'h0000, r[15:0]};
    endfunction

    function automatic int wrap_w(input int v, input int w);
        int m;
        int r;
        m = 1 << w;
        r = v % m;
        if (r < 0) r += m;
        if (r >= m / 2) r -= m;
        return r;
    endfunction

    function automatic int clamp_w(input int v, input int w);
        int hi;
        int lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 6; k++) begin
            m_acc[k]  = 0;
            m_bank[k] = 0;
        end
        m_cnt = 0; m_n = 0; m_satf = 1'b0; m_sat = 1'b0; m_valid = 1'b0; m_over = 1'b0;
    endtask

    task automatic model_step(input bit inv, input int iv, input int qv, input bit e,
                              input bit p, input bit l, input bit dmp, input bit rdy);
        int x;
        int t;
        int raw;
        bit ch;
        bit xf;
        bit ovw;
        if (inv) begin
            for (int k = 0; k < 6; k++) begin
                x   = (k % 2 == 1) ? qv : iv;
                ch  = (k < 2) ? e : ((k < 4) ? p : l);
                t   = ch ? -x : x;
                raw = m_acc[k] + t;
`ifdef ACC_SAT_EN
                if (clamp_w(raw, ACC_W) != raw) m_satf = 1'b1;
                m_acc[k] = clamp_w(raw, ACC_W);
`else
                m_acc[k] = wrap_w(raw, ACC_W);
`endif
            end
            if (m_cnt < 65535) m_cnt++;
        end
        xf  = m_valid && rdy;
        ovw = dmp && m_valid && !rdy;
        if (dmp) begin
            for (int k = 0; k < 6; k++) begin
                m_bank[k] = m_acc[k];
                m_acc[k]  = 0;
            end
            m_n = m_cnt; m_cnt = 0;
            m_sat = m_satf; m_satf = 1'b0;
            m_valid = 1'b1;
        end else if (xf) begin
            m_valid = 1'b0;
        end
        if (ovw) m_over = 1'b1;
        else if (xf) m_over = 1'b0;
    endtask

    task automatic check_all();
        chk("rd_valid", {31'd0, rd_valid}, {31'd0, m_valid});
        chk("overrun", {31'd0, overrun}, {31'd0, m_over});
        chk("sat", {31'd0, sat}, {31'd0, m_sat});
        chk("ie", {16'h0, ie}, e16(m_bank[0]));
        chk("qe", {16'h0, qe}, e16(m_bank[1]));
        chk("ip", {16'h0, ip}, e16(m_bank[2]));
        chk("qp", {16'h0, qp}, e16(m_bank[3]));
        chk("il", {16'h0, il}, e16(m_bank[4]));
        chk("ql", {16'h0, ql}, e16(m_bank[5]));
        chk("n_samples", {16'h0, n_samples}, e16(m_n));
    endtask

    task automatic step(input bit inv, input int iv, input int qv, input bit e,
                        input bit p, input bit l, input bit dmp, input bit rdy);
        in_valid = inv; i_in = 3'(iv); q_in = 3'(qv);
        early = e; prompt = p; late = l; dump_enable = dmp; rd_ready = rdy;
        @(posedge clk);
        model_step(inv, iv, qv, e, p, l, dmp, rdy);
        #1;
        check_all();
    endtask

    initial begin
        rstn = 1'b0; in_valid = 1'b0; i_in = 3'd0; q_in = 3'd0;
        early = 1'b0; prompt = 1'b0; late = 1'b0; dump_enable = 1'b0; rd_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        chk("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Reset mid-period: the partial period must vanish.
        for (int n = 0; n < 5; n++) step(1'b1, 3, -2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rstn = 1'b1;
        for (int n = 0; n < 2; n++) step(1'b1, 1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("post_reset_ip", {16'h0, ip}, e16(2));
        chk("post_reset_n", {16'h0, n_samples}, e16(2));
        step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Basic sum.
        for (int n = 0; n < 10; n++) step(1'b1, 1, -1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("pre_dump_valid", {31'd0, rd_valid}, 32'd0);
        step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("basic_valid", {31'd0, rd_valid}, 32'd1);
        chk("basic_ie", {16'h0, ie}, e16(10));
        chk("basic_qp", {16'h0, qp}, e16(-10));
        chk("basic_il", {16'h0, il}, e16(-10));
        chk("basic_ql", {16'h0, ql}, e16(10));
        chk("basic_n", {16'h0, n_samples}, e16(10));
        step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("read_clears_valid", {31'd0, rd_valid}, 32'd0);

        // The sample on the dump cycle belongs to the closing period.
        for (int n = 0; n < 4; n++) step(1'b1, 2, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 2, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("incl_ip", {16'h0, ip}, e16(10));
        chk("incl_n", {16'h0, n_samples}, e16(5));
        step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Overrun: a second dump lands while the bank is still unread.
        for (int n = 0; n < 3; n++) step(1'b1, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int n = 0; n < 2; n++) step(1'b1, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("ovr_flag", {31'd0, overrun}, 32'd1);
        chk("ovr_ip", {16'h0, ip}, e16(-2));
        step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovr_clear", {31'd0, overrun}, 32'd0);
        chk("ovr_valid_clear", {31'd0, rd_valid}, 32'd0);

        // Dump coincident with a transfer.
        step(1'b1, 1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int n = 0; n < 2; n++) step(1'b1, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("coinc_valid", {31'd0, rd_valid}, 32'd1);
        chk("coinc_overrun", {31'd0, overrun}, 32'd0);
        chk("coinc_ip", {16'h0, ip}, e16(6));
        step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Overflow on the 8-bit instance.
        for (int n = 0; n < 50; n++) step(1'b1, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef ACC_SAT_EN
        chk("ovf8_ip", {24'h0, ip8}, 32'h7F);
        chk("ovf8_sat", {31'd0, sat8}, 32'd1);
`else
        chk("ovf8_ip", {24'h0, ip8}, 32'h96);
        chk("ovf8_sat", {31'd0, sat8}, 32'd0);
`endif
        chk("ovf16_ip", {16'h0, ip}, e16(150));
        step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)) - 4,
                 int'($urandom_range(0, 7)) - 4, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
